// File: rtl/priv_1_13_trap_sequencer.sv
// Trap / xRET sequencer: flush request, drain wait, one-cycle CSR commit,
// then fetch redirect to the trap vector or return PC at the new privilege.
module priv_1_13_trap_sequencer #(
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        intr,
    input  logic        intr_to_s,
    input  logic        is_interrupt,
    input  logic [4:0]  cause,
    input  logic        mret,
    input  logic        sret,
    input  logic [1:0]  mpp,
    input  logic        spp,
    input  logic        pipe_clear,
    input  logic        ex_mem_stall,
    input  logic [31:0] mtvec,
    input  logic [31:0] stvec,
    input  logic [31:0] mepc,
    input  logic [31:0] sepc,
    input  logic        insert_ack,
    output logic        flush_req,
    output logic        commit,
    output logic        insert_pc,
    output logic [31:0] priv_pc,
    output logic [1:0]  next_priv,
    output logic        busy,
    output logic        drain_timeout
);

    localparam int CW = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_DRAIN, COMMIT, REDIRECT} state_e;
    typedef enum logic [1:0] {K_TRAP, K_MRET, K_SRET} kind_e;

    state_e        state_q, state_d;
    kind_e         kind_q, kind_d;
    logic [4:0]    cause_q, cause_d;
    logic          is_int_q, is_int_d;
    logic          to_s_q, to_s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
    logic [31:0]   pc_q, pc_d;
    logic [1:0]    priv_q, priv_d;
    logic          flush_q, flush_d;
    logic          commit_q, commit_d;
    logic          ins_q, ins_d;
    logic          busy_q, busy_d;

    logic [31:0]   tvec, base, tgt;
    logic [1:0]    npriv;

    always_comb begin
        tvec  = to_s_q ? stvec : mtvec;
        base  = tvec & 32'hFFFF_FFFC;
        tgt   = base;
        npriv = to_s_q ? 2'b01 : 2'b11;
        unique case (kind_q)
            K_TRAP: begin
                // Vectored mode offsets interrupts only; exceptions use base.
                if (tvec[1:0] == 2'b01 && is_int_q)
                    tgt = base + {25'd0, cause_q, 2'b00};
            end
            K_MRET: begin
                tgt   = mepc & 32'hFFFF_FFFE;
                npriv = mpp;
            end
            K_SRET: begin
                tgt   = sepc & 32'hFFFF_FFFE;
                npriv = {1'b0, spp};
            end
            default: begin
                tgt = base;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cause_d  = cause_q;
        is_int_d = is_int_q;
        to_s_d   = to_s_q;
        cnt_d    = cnt_q;
        to_d     = to_q;
        pc_d     = pc_q;
        priv_d   = priv_q;
        unique case (state_q)
            IDLE: begin
                if (intr) begin
                    kind_d   = K_TRAP;
                    cause_d  = cause;
                    is_int_d = is_interrupt;
                    to_s_d   = intr_to_s;
                    state_d  = WAIT_DRAIN;
                end else if (mret) begin
                    kind_d  = K_MRET;
                    state_d = WAIT_DRAIN;
                end else if (sret) begin
                    kind_d  = K_SRET;
                    state_d = WAIT_DRAIN;
                end
            end
            WAIT_DRAIN: begin
                if (cnt_q != CW'(DRAIN_TIMEOUT))
                    cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DRAIN_TIMEOUT - 1))
                    to_d = 1'b1;
                if (kind_q == K_TRAP && is_int_q && !intr) begin
                    state_d = IDLE;
                end else if (pipe_clear && !ex_mem_stall) begin
                    state_d = COMMIT;
                    priv_d  = npriv;
                end
            end
            COMMIT: begin
                state_d = REDIRECT;
                pc_d    = tgt;
            end
            REDIRECT: begin
                if (insert_ack)
                    state_d = IDLE;
            end
        endcase
        if (state_d != WAIT_DRAIN)
            cnt_d = '0;
        flush_d  = (state_d != IDLE);
        busy_d   = (state_d != IDLE);
        commit_d = (state_d == COMMIT);
        ins_d    = (state_d == REDIRECT);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            kind_q   <= K_TRAP;
            cause_q  <= '0;
            is_int_q <= 1'b0;
            to_s_q   <= 1'b0;
            cnt_q    <= '0;
            to_q     <= 1'b0;
            pc_q     <= '0;
            priv_q   <= '0;
            flush_q  <= 1'b0;
            commit_q <= 1'b0;
            ins_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cause_q  <= cause_d;
            is_int_q <= is_int_d;
            to_s_q   <= to_s_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            pc_q     <= pc_d;
            priv_q   <= priv_d;
            flush_q  <= flush_d;
            commit_q <= commit_d;
            ins_q    <= ins_d;
            busy_q   <= busy_d;
        end
    end

    assign flush_req     = flush_q;
    assign commit        = commit_q;
    assign insert_pc     = ins_q;
    assign priv_pc       = pc_q;
    assign next_priv     = priv_q;
    assign busy          = busy_q;
    assign drain_timeout = to_q;

endmodule

// File: tb/tb_priv_1_13_trap_sequencer.sv
// Bench for the trap sequencer: directed scenarios plus randomized
// sequences checked against a transaction-level reference model.
module tb_priv_1_13_trap_sequencer;

    logic        CLK, nRST;
    logic        intr, intr_to_s, is_interrupt;
    logic [4:0]  cause;
    logic        mret, sret;
    logic [1:0]  mpp;
    logic        spp;
    logic        pipe_clear, ex_mem_stall;
    logic [31:0] mtvec, stvec, mepc, sepc;
    logic        insert_ack;
    logic        flush_req, commit, insert_pc;
    logic [31:0] priv_pc;
    logic [1:0]  next_priv;
    logic        busy, drain_timeout;

    int checks = 0;
    int errors = 0;
    bit model_to = 0;

    priv_1_13_trap_sequencer #(.DRAIN_TIMEOUT(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .intr(intr), .intr_to_s(intr_to_s),
        .is_interrupt(is_interrupt), .cause(cause),
        .mret(mret), .sret(sret), .mpp(mpp), .spp(spp),
        .pipe_clear(pipe_clear), .ex_mem_stall(ex_mem_stall),
        .mtvec(mtvec), .stvec(stvec), .mepc(mepc), .sepc(sepc),
        .insert_ack(insert_ack),
        .flush_req(flush_req), .commit(commit), .insert_pc(insert_pc),
        .priv_pc(priv_pc), .next_priv(next_priv),
        .busy(busy), .drain_timeout(drain_timeout)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL global_timeout: sim still running at %0t, limit 300000", $time);
        $fatal(1);
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // k: 0 trap, 1 mret, 2 sret, 3 trap and mret together
    function automatic logic [31:0] exp_pc(int k, bit ts, bit ii, logic [4:0] c,
        logic [31:0] mt, logic [31:0] st, logic [31:0] me, logic [31:0] se);
        logic [31:0] tv;
        if (k == 1) return me - (me % 2);
        if (k == 2) return se - (se % 2);
        tv = ts ? st : mt;
        if (tv % 4 == 1 && ii) return 32'(tv - (tv % 4) + 32'(c) * 4);
        return tv - (tv % 4);
    endfunction

    function automatic logic [1:0] exp_priv(int k, bit ts, logic [1:0] mp, bit sp);
        if (k == 1) return mp;
        if (k == 2) return {1'b0, sp};
        return ts ? 2'd1 : 2'd3;
    endfunction

    task automatic run_seq(input int k, input bit ii, input bit ts,
        input logic [4:0] c, input int drain, input bit stl, input int ackd);
        logic [31:0] epc;
        logic [1:0]  ep;
        int wd;
        ep  = exp_priv(k, ts, mpp, spp);
        epc = exp_pc(k, ts, ii, c, mtvec, stvec, mepc, sepc);
        intr = (k == 0 || k == 3);
        mret = (k == 1 || k == 3);
        sret = (k == 2);
        is_interrupt = ii;
        intr_to_s = ts;
        cause = c;
        pipe_clear = 0;
        ex_mem_stall = 0;
        insert_ack = 0;
        step;
        wd = 0;
        checks++;
        if (busy !== 1'b1 || flush_req !== 1'b1 || commit !== 1'b0 || insert_pc !== 1'b0) begin
            errors++;
            $display("FAIL accept: busy=%b flush=%b commit=%b ins=%b want 1 1 0 0",
                busy, flush_req, commit, insert_pc);
        end
        if (!((k == 0 || k == 3) && ii)) intr = 0;
        mret = 0;
        sret = 0;
        cause = 5'($urandom);
        is_interrupt = 1'($urandom);
        intr_to_s = 1'($urandom);
        for (int i = 0; i < drain; i++) begin
            pipe_clear = stl;
            ex_mem_stall = stl ? 1'b1 : 1'($urandom);
            step;
            wd++;
            if (wd >= 8) model_to = 1;
            checks++;
            if (commit !== 1'b0 || busy !== 1'b1 || flush_req !== 1'b1
                || drain_timeout !== model_to) begin
                errors++;
                $display("FAIL drain_wait: commit=%b busy=%b flush=%b to=%b want 0 1 1 %b",
                    commit, busy, flush_req, drain_timeout, model_to);
            end
        end
        pipe_clear = 1;
        ex_mem_stall = 0;
        step;
        wd++;
        if (wd >= 8) model_to = 1;
        checks++;
        if (commit !== 1'b1 || next_priv !== ep || insert_pc !== 1'b0
            || flush_req !== 1'b1 || drain_timeout !== model_to) begin
            errors++;
            $display("FAIL commit: commit=%b priv=%0d ins=%b flush=%b to=%b want 1 %0d 0 1 %b",
                commit, next_priv, insert_pc, flush_req, drain_timeout, ep, model_to);
        end
        pipe_clear = 0;
        intr = 0;
        step;
        checks++;
        if (commit !== 1'b0 || insert_pc !== 1'b1 || priv_pc !== epc || flush_req !== 1'b1) begin
            errors++;
            $display("FAIL redirect: commit=%b ins=%b pc=%h flush=%b want 0 1 %h 1",
                commit, insert_pc, priv_pc, flush_req, epc);
        end
        mtvec = $urandom;
        stvec = $urandom;
        mepc = $urandom;
        sepc = $urandom;
        mpp = 2'($urandom);
        spp = 1'($urandom);
        for (int i = 0; i < ackd; i++) begin
            step;
            checks++;
            if (insert_pc !== 1'b1 || priv_pc !== epc || commit !== 1'b0) begin
                errors++;
                $display("FAIL pc_hold: ins=%b pc=%h commit=%b want 1 %h 0",
                    insert_pc, priv_pc, commit, epc);
            end
        end
        insert_ack = 1;
        step;
        insert_ack = 0;
        checks++;
        if (busy !== 1'b0 || insert_pc !== 1'b0 || flush_req !== 1'b0 || commit !== 1'b0) begin
            errors++;
            $display("FAIL return_idle: busy=%b ins=%b flush=%b commit=%b want 0 0 0 0",
                busy, insert_pc, flush_req, commit);
        end
    endtask

    task automatic test_reset;
        nRST = 0;
        intr = 0; intr_to_s = 0; is_interrupt = 0; cause = 0;
        mret = 0; sret = 0; mpp = 0; spp = 0;
        pipe_clear = 0; ex_mem_stall = 0; insert_ack = 0;
        mtvec = 0; stvec = 0; mepc = 0; sepc = 0;
        repeat (2) step;
        checks++;
        if ({flush_req, commit, insert_pc, busy, drain_timeout} !== 5'b0
            || priv_pc !== 32'd0 || next_priv !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: f/c/i/b/t=%b pc=%h priv=%0d want 00000 0 0",
                {flush_req, commit, insert_pc, busy, drain_timeout}, priv_pc, next_priv);
        end
        nRST = 1;
        step;
    endtask

    task automatic test_exception;
        mtvec = 32'h8000_0100;
        run_seq(0, 0, 0, 5'd2, 3, 0, 2);
    endtask

    task automatic test_vectored;
        mtvec = 32'h8000_0001;
        run_seq(0, 1, 0, 5'd7, 1, 0, 1);
        mtvec = 32'h8000_0003;
        run_seq(0, 1, 0, 5'd7, 0, 0, 0);
        mtvec = 32'hFFFF_FFFD;
        run_seq(0, 1, 0, 5'd31, 2, 0, 0);
    endtask

    task automatic test_delegated;
        stvec = 32'h4000_0000;
        mtvec = 32'h8000_0000;
        run_seq(0, 0, 1, 5'd8, 2, 0, 1);
        stvec = 32'h4000_0101;
        run_seq(0, 1, 1, 5'd5, 1, 0, 0);
    endtask

    task automatic test_xret;
        mepc = 32'h0000_1234;
        mpp = 2'b00;
        run_seq(1, 0, 0, 5'd0, 2, 0, 1);
        sepc = 32'h0000_5677;
        spp = 1;
        run_seq(2, 0, 0, 5'd0, 1, 0, 0);
        mtvec = 32'h8000_0100;
        mepc = 32'h0000_1234;
        mpp = 2'b00;
        run_seq(3, 0, 0, 5'd3, 1, 0, 0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            mtvec = $urandom;
            mepc = $urandom;
            run_seq(i % 2, 0, 0, 5'($urandom), 0, 0, 0);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            mtvec = $urandom;
            stvec = $urandom;
            mepc = $urandom;
            sepc = $urandom;
            mpp = 2'($urandom);
            spp = 1'($urandom);
            if ($urandom_range(0, 2) == 0) mtvec[1:0] = 2'b01;
            if ($urandom_range(0, 2) == 0) stvec[1:0] = 2'b01;
            run_seq($urandom_range(0, 3), 1'($urandom), 1'($urandom), 5'($urandom),
                $urandom_range(0, 6), 1'($urandom), $urandom_range(0, 3));
        end
    endtask

    task automatic test_stall_timeout;
        mepc = 32'h0000_2000;
        mpp = 2'b11;
        run_seq(1, 0, 0, 5'd0, 5, 1, 0);
        checks++;
        if (drain_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: to=%b want 0", drain_timeout);
        end
        mtvec = 32'h8000_0100;
        run_seq(0, 0, 0, 5'd2, 10, 0, 1);
        run_seq(0, 0, 0, 5'd2, 0, 0, 0);
        checks++;
        if (drain_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: to=%b want 1", drain_timeout);
        end
    endtask

    task automatic test_withdraw_reset;
        intr = 1;
        is_interrupt = 1;
        cause = 5'd7;
        step;
        repeat (2) step;
        intr = 0;
        step;
        checks++;
        if (busy !== 1'b0 || flush_req !== 1'b0 || commit !== 1'b0) begin
            errors++;
            $display("FAIL withdraw: busy=%b flush=%b commit=%b want 0 0 0",
                busy, flush_req, commit);
        end
        for (int i = 0; i < 3; i++) begin
            pipe_clear = 1;
            step;
            checks++;
            if (commit !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL withdraw_idle: commit=%b busy=%b want 0 0", commit, busy);
            end
        end
        pipe_clear = 0;
        mret = 1;
        mpp = 2'b11;
        mepc = 32'h0000_4444;
        step;
        mret = 0;
        pipe_clear = 1;
        step;
        pipe_clear = 0;
        step;
        checks++;
        if (insert_pc !== 1'b1 || priv_pc !== 32'h0000_4444) begin
            errors++;
            $display("FAIL pre_reset_redirect: ins=%b pc=%h want 1 00004444", insert_pc, priv_pc);
        end
        #2 nRST = 0;
        #1;
        model_to = 0;
        checks++;
        if ({flush_req, commit, insert_pc, busy, drain_timeout} !== 5'b0
            || priv_pc !== 32'd0 || next_priv !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: f/c/i/b/t=%b pc=%h priv=%0d want 00000 0 0",
                {flush_req, commit, insert_pc, busy, drain_timeout}, priv_pc, next_priv);
        end
        @(negedge CLK);
        nRST = 1;
        step;
        checks++;
        if (busy !== 1'b0 || drain_timeout !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: busy=%b to=%b want 0 0", busy, drain_timeout);
        end
        sepc = 32'h0000_0100;
        spp = 0;
        run_seq(2, 0, 0, 5'd0, 1, 0, 0);
    endtask

    initial begin
        test_reset;
        test_exception;
        test_vectored;
        test_delegated;
        test_xret;
        test_back_to_back;
        test_random;
        test_stall_timeout;
        test_withdraw_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
